serial_operand_shifter: RTL and testbench

SERIAL_OPERAND_SHIFTER -- requirements
Module: serial_operand_shifter

---
 rtl/serial_pkg.sv | 11 +
 rtl/piso_reg.sv | 33 +++
 rtl/serial_operand_shifter.sv | 128 ++++++++++++
 tb/tb_serial_operand_shifter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared FSM state type and default operand width for serial_operand_shifter and piso_reg.
package serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : serial_pkg

// File: rtl/piso_reg.sv
// Parallel-load, shift-right register; presents its LSB as the serial output.
module piso_reg
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  // Abort wins over load, load wins over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sout = q[0];

endmodule : piso_reg

// File: rtl/serial_operand_shifter.sv
// Serialises an operand pair LSB-first for a bit-serial adder.
// Optional subtract support (input sub, output cin_set) under SERIAL_OPERAND_SUB_EN.
module serial_operand_shifter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
`ifdef SERIAL_OPERAND_SUB_EN
  input  logic             sub,
  output logic             cin_set,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, shift;
  logic          a_sout, b_sout;
  logic          at_last;

  assign at_last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and register controls; clr overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift = 1'b1;
          if (at_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  piso_reg #(.WIDTH(WIDTH)) u_piso_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .shift (shift),
    .d     (a_in),
    .sout  (a_sout)
  );

  piso_reg #(.WIDTH(WIDTH)) u_piso_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .shift (shift),
    .d     (b_in),
    .sout  (b_sout)
  );

  // Serial outputs are gated decodes of registered state, so they read 0 outside a burst.
  assign in_ready  = (state_q == IDLE);
  assign bit_valid = (state_q == SHIFT);
  assign a_bit     = bit_valid & a_sout;
  assign first_bit = bit_valid & (cnt_q == '0);
  assign last_bit  = bit_valid & at_last;

`ifdef SERIAL_OPERAND_SUB_EN
  logic sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (clr) begin
      sub_q <= 1'b0;
    end else if (load) begin
      sub_q <= sub;
    end
  end

  // Inverting B with carry-in 1 forms A - B.
  assign b_bit   = bit_valid & (b_sout ^ sub_q);
  assign cin_set = first_bit & sub_q;
`else
  assign b_bit = bit_valid & b_sout;
`endif

endmodule : serial_operand_shifter

// File: tb/tb_serial_operand_shifter.sv
// Randomised self-checking bench for serial_operand_shifter against a burst-level reference model.
module tb_serial_operand_shifter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         in_ready, a_bit, b_bit, bit_valid, first_bit, last_bit;
`ifdef SERIAL_OPERAND_SUB_EN
  logic         sub = 1'b0;
  logic         cin_set;
`endif

  serial_operand_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
`ifdef SERIAL_OPERAND_SUB_EN
    .sub       (sub),
    .cin_set   (cin_set),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .bit_valid (bit_valid),
    .first_bit (first_bit),
    .last_bit  (last_bit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: one captured operand pair plus the index of the bit being presented.
  bit           m_active = 1'b0;
  int           m_k      = 0;
  logic [W-1:0] m_a      = '0;
  logic [W-1:0] m_b      = '0;
  bit           m_sub    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outs();
    logic ea, eb;
    ea = m_active ? m_a[m_k] : 1'b0;
    eb = m_active ? (m_b[m_k] ^ m_sub) : 1'b0;
    check("in_ready", 32'(in_ready), 32'(!m_active));
    check("bit_valid", 32'(bit_valid), 32'(m_active));
    check("a_bit", 32'(a_bit), 32'(ea));
    check("b_bit", 32'(b_bit), 32'(eb));
    check("first_bit", 32'(first_bit), 32'(m_active && m_k == 0));
    check("last_bit", 32'(last_bit), 32'(m_active && m_k == int'(W) - 1));
`ifdef SERIAL_OPERAND_SUB_EN
    check("cin_set", 32'(cin_set), 32'(m_active && m_k == 0 && m_sub));
`endif
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check outputs.
  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit c, input bit s);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    clr      = c;
`ifdef SERIAL_OPERAND_SUB_EN
    sub = s;
`endif
    #1;
    check("in_ready_pre", 32'(in_ready), 32'(!m_active));
    @(posedge clk);
    if (c) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_k == int'(W) - 1) m_active = 1'b0;
      else m_k++;
    end else if (v) begin
      m_active = 1'b1;
      m_k      = 0;
      m_a      = a;
      m_b      = b;
`ifdef SERIAL_OPERAND_SUB_EN
      m_sub = s;
`else
      m_sub = 1'b0;
      if (s) m_sub = 1'b0;
`endif
    end
    #1;
    check_outs();
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    // Reset state
    #2;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed pair 0x35 / 0x0F, A changing under the burst
    step(1'b1, 8'h35, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < int'(W) + 2; i++) step(1'b0, rnd(), rnd(), 1'b0, 1'b0);

    // Subtract-mode pair (only observable with the optional feature)
    step(1'b1, 8'h35, 8'h0F, 1'b0, 1'b1);
    for (int i = 0; i < int'(W) + 1; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b0);

    // in_valid held high: back-to-back bursts with one idle cycle between
    for (int i = 0; i < 3 * (int'(W) + 1); i++) step(1'b1, rnd(), rnd(), 1'b0, 1'($urandom));

    // clr while bit 3 is presented
    while (m_active) step(1'b0, rnd(), rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    check("clr_at_bit3", 32'(m_k), 32'd3);
    step(1'b1, rnd(), rnd(), 1'b1, 1'b0);
    step(1'b0, rnd(), rnd(), 1'b0, 1'b0);

    // Asynchronous reset mid-burst
    step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0);
    step(1'b0, rnd(), rnd(), 1'b0, 1'b0);
    step(1'b0, rnd(), rnd(), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) step(1'b0, rnd(), rnd(), 1'b0, 1'b0);

    // Random traffic with occasional aborts
    for (int i = 0; i < 400; i++)
      step(($urandom % 3) != 0, rnd(), rnd(), ($urandom % 20) == 0, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_operand_shifter
